// File: rtl/dcache_ctrl.sv
// Miss/refill and write-through sequencer for a direct-mapped D-cache; stalls the core (comb) on load miss or store.
// Zero-wait latency: miss stalls WORDS_PER_LINE+1 cycles, store 2; memory backpressure via req/ack holds req/addr/data.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W = $clog2(WORDS_PER_LINE)
) (
  input  logic              i_clk,
  input  logic              i_areset,
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_hit,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_fill_we,
  output logic [OFF_W-1:0]  o_fill_idx,
  output logic [DATA_W-1:0] o_fill_data,
  output logic              o_tag_we,
  output logic [ADDR_W-1:0] o_tag_addr,
  output logic              o_wt_done
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(WORDS_PER_LINE - 1);

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] line_base, word_addr;
  logic              ack;
  logic              unused_addr_lsb;

  // Byte offset within a word never reaches memory; only word addresses are issued.
  assign unused_addr_lsb = ^i_cpu_addr[1:0];
  assign ack       = mem_req_q & i_mem_ack;
  assign cnt_inc   = cnt_q + OFF_W'(1);
  assign line_base = {i_cpu_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign word_addr = {i_cpu_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    o_stall     = 1'b0;
    o_fill_we   = 1'b0;
    o_tag_we    = 1'b0;
    o_wt_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cpu_wr) begin
          o_stall     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr;
          mem_wdata_d = i_cpu_wdata;
          state_d     = WRITE;
        end else if (i_cpu_rd && !i_hit) begin
          o_stall    = 1'b1;
          base_d     = line_base;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_base;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        o_stall = 1'b1;
        if (ack) begin
          o_fill_we = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_q == LAST_IDX) begin
            // Tag/valid only on the final word, so an aborted refill leaves the line invalid.
            o_tag_we   = 1'b1;
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
            state_d    = DONE;
          end else begin
            mem_addr_d = base_q | ADDR_W'({cnt_inc, 2'b00});
          end
        end
      end
      WRITE: begin
        o_stall = 1'b1;
        if (ack) begin
          o_wt_done   = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_areset) o_stall = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_fill_idx  = cnt_q;
  assign o_fill_data = o_fill_we ? i_mem_rdata : '0;
  assign o_tag_addr  = o_tag_we ? base_q : '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected memory/fill/tag/wt events, a monitor pops and compares.
module tb_dcache_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPL = 4;
  localparam int OW  = 2;

  logic          clk;
  logic          i_areset;
  logic          i_cpu_rd, i_cpu_wr, i_hit;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_stall, o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          o_fill_we;
  logic [OW-1:0] o_fill_idx;
  logic [DW-1:0] o_fill_data;
  logic          o_tag_we;
  logic [AW-1:0] o_tag_addr;
  logic          o_wt_done;

  dcache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) dut (
    .i_clk(clk), .i_areset(i_areset), .i_cpu_rd(i_cpu_rd), .i_cpu_wr(i_cpu_wr),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata), .i_hit(i_hit),
    .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_fill_we(o_fill_we), .o_fill_idx(o_fill_idx),
    .o_fill_data(o_fill_data), .o_tag_we(o_tag_we), .o_tag_addr(o_tag_addr),
    .o_wt_done(o_wt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} mem_exp_t;
  typedef struct packed {logic [OW-1:0] idx; logic [31:0] data;} fill_exp_t;

  mem_exp_t    exp_mem[$];
  fill_exp_t   exp_fill[$];
  logic [31:0] exp_tag[$];
  logic [31:0] exp_wt[$];
  int          resp_waits[$];
  int          wleft = -1;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];
  int          n_pass = 0, n_total = 0;
  int          n_fill = 0, n_tag = 0;
  mem_exp_t    mon_e;
  fill_exp_t   mon_f;
  logic [31:0] mon_a;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endfunction

  function automatic void fail_note(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s", name, what);
  endfunction

  function automatic logic [31:0] dflt_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt_word(a);
  endfunction

  function automatic logic [31:0] env_word(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt_word(a);
  endfunction

  // Memory responder: per-request wait counts come from the stimulus; stray acks when idle.
  always @(negedge clk) begin
    if (o_mem_req) begin
      if (wleft < 0) begin
        wleft = 0;
        if (resp_waits.size() > 0) wleft = resp_waits.pop_front();
      end
      if (wleft == 0) begin
        i_mem_ack = 1'b1;
        if (o_mem_we) begin
          env_mem[o_mem_addr] = o_mem_wdata;
          i_mem_rdata = $urandom;
        end else begin
          i_mem_rdata = env_word(o_mem_addr);
        end
        wleft = -1;
      end else begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = $urandom;
        wleft--;
      end
    end else begin
      i_mem_ack   = 1'($urandom_range(0, 1));
      i_mem_rdata = $urandom;
    end
  end

  // Monitor
  always @(negedge clk) begin
    #2;
    if (!i_areset) begin
      if (o_mem_req) begin
        if (exp_mem.size() == 0) begin
          fail_note("unexpected_mem_req", $sformatf("got addr 0x%08h, want no request", o_mem_addr));
        end else begin
          mon_e = exp_mem[0];
          chk("mem_addr", o_mem_addr, mon_e.addr);
          chk("mem_we", 32'(o_mem_we), 32'(mon_e.we));
          if (mon_e.we) chk("mem_wdata", o_mem_wdata, mon_e.wdata);
          if (i_mem_ack) void'(exp_mem.pop_front());
        end
      end
      if (o_fill_we) begin
        n_fill++;
        if (exp_fill.size() == 0) begin
          fail_note("unexpected_fill", $sformatf("got idx %0d, want no fill", o_fill_idx));
        end else begin
          mon_f = exp_fill.pop_front();
          chk("fill_idx", 32'(o_fill_idx), 32'(mon_f.idx));
          chk("fill_data", o_fill_data, mon_f.data);
        end
      end
      if (o_tag_we) begin
        n_tag++;
        if (exp_tag.size() == 0) begin
          fail_note("unexpected_tag_we", $sformatf("got addr 0x%08h, want no tag write", o_tag_addr));
        end else begin
          mon_a = exp_tag.pop_front();
          chk("tag_addr", o_tag_addr, mon_a);
        end
      end
      if (o_wt_done) begin
        chk("wt_done_on_ack", 32'(i_mem_ack & o_mem_req), 32'd1);
        if (exp_wt.size() == 0) begin
          fail_note("unexpected_wt_done", "got pulse, want none");
        end else begin
          mon_a = exp_wt.pop_front();
          chk("wt_done_addr", o_mem_addr, mon_a);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_stall"}, 32'(o_stall), 32'd0);
    chk({name, "_mem_req"}, 32'(o_mem_req), 32'd0);
    chk({name, "_mem_we"}, 32'(o_mem_we), 32'd0);
    chk({name, "_mem_addr"}, o_mem_addr, 32'd0);
    chk({name, "_mem_wdata"}, o_mem_wdata, 32'd0);
    chk({name, "_fill_we"}, 32'(o_fill_we), 32'd0);
    chk({name, "_tag_we"}, 32'(o_tag_we), 32'd0);
    chk({name, "_wt_done"}, 32'(o_wt_done), 32'd0);
  endtask

  task automatic issue_load(input logic [31:0] addr, input bit hit, input int minw,
                            input int maxw, output int exp_stall);
    logic [31:0] base;
    int w;
    base = addr & ~32'(WPL * 4 - 1);
    exp_stall = 0;
    if (!hit) begin
      exp_stall = 1;
      for (int k = 0; k < WPL; k++) begin
        w = $urandom_range(maxw, minw);
        resp_waits.push_back(w);
        exp_stall += w + 1;
        exp_mem.push_back('{addr: base + 32'(4 * k), we: 1'b0, wdata: 32'd0});
        exp_fill.push_back('{idx: OW'(k), data: ref_word(base + 32'(4 * k))});
      end
      exp_tag.push_back(base);
    end
    i_cpu_rd    = 1'b1;
    i_cpu_wr    = 1'b0;
    i_cpu_addr  = addr;
    i_hit       = hit;
    i_cpu_wdata = $urandom;
  endtask

  task automatic wait_release(input string name, input int exp_stall);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      #2;
      if (o_stall) n++;
      else done = 1'b1;
    end
    if (!done) fail_note({name, "_stall_timeout"}, "got stall stuck high for 400 cycles, want release");
    else chk({name, "_stall_cycles"}, n, exp_stall);
    @(posedge clk);
    #1;
    i_cpu_rd = 1'b0;
    i_cpu_wr = 1'b0;
    i_hit    = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input bit hit, input int minw,
                         input int maxw, input string name);
    int s;
    issue_load(addr, hit, minw, maxw, s);
    wait_release(name, s);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int w);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    resp_waits.push_back(w);
    exp_mem.push_back('{addr: a, we: 1'b1, wdata: data});
    exp_wt.push_back(a);
    ref_mem[a]  = data;
    i_cpu_wr    = 1'b1;
    i_cpu_rd    = 1'($urandom_range(0, 1));
    i_hit       = 1'($urandom_range(0, 1));
    i_cpu_addr  = addr;
    i_cpu_wdata = data;
    wait_release("store", w + 2);
  endtask

  initial begin
    int  f0, t0, s;
    bit  done;
    logic [31:0] a;
    i_areset    = 1'b1;
    i_cpu_rd    = 1'b1;
    i_cpu_wr    = 1'b1;
    i_hit       = 1'b0;
    i_cpu_addr  = $urandom;
    i_cpu_wdata = $urandom;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    #2;
    check_zero("reset_init");
    repeat (2) @(posedge clk);
    #1;
    i_cpu_rd = 1'b0;
    i_cpu_wr = 1'b0;
    i_areset = 1'b0;

    do_load(32'h0000_0100, 1'b1, 0, 0, "load_hit");

    for (int k = 0; k < 4; k++) begin
      a = 32'h120 + 32'(4 * k);
      ref_mem[a] = 32'hA0 + 32'(k);
      env_mem[a] = 32'hA0 + 32'(k);
    end
    do_load(32'h0000_0124, 1'b0, 0, 0, "miss_zero_wait");
    do_load(32'h0000_0348, 1'b0, 3, 3, "miss_wait3");
    do_store(32'h0000_0203, 32'hDEAD_BEEF, 2);

    // Abort a refill after two words, then repeat the miss to the same line.
    f0 = n_fill;
    t0 = n_tag;
    issue_load(32'h0000_03A4, 1'b0, 0, 0, s);
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      #3;
      if (n_fill - f0 >= 2) done = 1'b1;
    end
    if (!done) fail_note("refill_progress_timeout", "got fewer than 2 fills in 50 cycles, want 2");
    @(posedge clk);
    #2;
    i_areset = 1'b1;
    exp_mem.delete();
    exp_fill.delete();
    exp_tag.delete();
    resp_waits.delete();
    wleft = -1;
    #1;
    check_zero("reset_mid_refill");
    i_cpu_rd = 1'b0;
    @(posedge clk);
    #1;
    i_areset = 1'b0;
    chk("fills_before_reset", n_fill - f0, 2);
    chk("no_tag_on_abort", n_tag - t0, 0);
    do_load(32'h0000_03A4, 1'b0, 0, 1, "miss_after_reset");
    chk("tag_after_restart", n_tag - t0, 1);

    repeat (60) begin
      a = 32'h1000 | 32'($urandom_range(0, 1023));
      case ($urandom_range(0, 2))
        0: do_load(a, 1'b1, 0, 0, "rand_hit");
        1: do_load(a, 1'b0, 0, 3, "rand_miss");
        default: do_store(a, $urandom, $urandom_range(0, 3));
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    chk("exp_mem_drained", exp_mem.size(), 0);
    chk("exp_fill_drained", exp_fill.size(), 0);
    chk("exp_tag_drained", exp_tag.size(), 0);
    chk("exp_wt_drained", exp_wt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Miss/refill and write-through sequencer for the direct-mapped data cache of the single-cycle RV32 core. It watches core load/store requests and the cache's tag-compare result. On a load miss it stalls the core, fetches the full line from memory word by word through a req/ack handshake, writes each word into the data array, and sets tag/valid. On a store it stalls the core until memory acknowledges the write-through.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
WORDS_PER_LINE, 4, words per cache line; power of 2, >=2; OFF_W = log2(WORDS_PER_LINE)

Ports:
i_clk  input  1  clock, rising edge
i_areset  input  1  asynchronous reset, active-high
i_cpu_rd  input  1  core load this cycle
i_cpu_wr  input  1  core store this cycle
i_cpu_addr  input  ADDR_W  core byte address
i_cpu_wdata  input  DATA_W  core store data
i_hit  input  1  tag match and valid for i_cpu_addr (combinational, from cache)
o_stall  output  1  freeze PC/pipeline (combinational)
o_mem_req  output  1  memory request, registered
o_mem_we  output  1  1 = write, 0 = read, registered
o_mem_addr  output  ADDR_W  word-aligned memory address, registered
o_mem_wdata  output  DATA_W  write data, registered
i_mem_ack  input  1  memory accepts/completes the current request
i_mem_rdata  input  DATA_W  read data, valid with i_mem_ack on reads
o_fill_we  output  1  write one word into the data array
o_fill_idx  output  OFF_W  word index within the line for o_fill_we
o_fill_data  output  DATA_W  word to write (= i_mem_rdata)
o_tag_we  output  1  write tag of the latched line address and set valid
o_tag_addr  output  ADDR_W  line base address for the tag/index write
o_wt_done  output  1  one-cycle pulse: store committed; cache updates the word if hit

Behaviour:
- States: IDLE, REFILL, WRITE, DONE. Reset: state IDLE, word counter 0, latched address/data 0.
- Reset outputs: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_fill_we, o_tag_we, o_wt_done all 0; o_stall 0.
- o_stall = (IDLE & ((i_cpu_rd & ~i_hit) | i_cpu_wr)) | REFILL | WRITE. In DONE it is 0.
- IDLE, store (i_cpu_wr=1; wins if i_cpu_rd also set): latch addr[ADDR_W-1:2],2'b00 and wdata. Go to WRITE with o_mem_req=1 and o_mem_we=1.
- IDLE, load miss (i_cpu_rd & ~i_hit): latch line base (low OFF_W+2 bits zeroed) and clear the counter. Go to REFILL with o_mem_req=1, o_mem_we=0, o_mem_addr=base.
- IDLE, load hit or no request: stay, all outputs 0.
- REFILL: o_mem_addr = base + (cnt<<2), held stable until ack.
  - On i_mem_ack: o_fill_we=1, o_fill_idx=cnt, o_fill_data=i_mem_rdata in the same cycle (combinational); cnt increments.
  - When cnt = WORDS_PER_LINE-1 and ack: o_tag_we=1 with o_tag_addr=base in the same cycle. Deassert o_mem_req and go to DONE.
- WRITE: hold req/we/addr/wdata until i_mem_ack. On ack: o_mem_req<=0, o_wt_done=1 in the ack cycle, go to DONE.
- DONE: one cycle, stall released so the core retires the instruction (a load now hits). New requests are ignored. Next state is IDLE.
- i_mem_ack while o_mem_req=0 is ignored. Wait states are unbounded; there is no timeout.
- Counter wraps only via reset to 0 at miss entry; no partial-line tag write ever occurs.
- i_areset mid-operation: immediate return to IDLE. o_tag_we is never issued, so the line stays invalid. o_mem_req drops asynchronously.
- Latency: load miss with zero-wait memory stalls WORDS_PER_LINE+1 cycles; store with zero-wait memory stalls 2 cycles.

Test Plan:
- Reset: assert i_areset mid-cycle with random inputs -> all outputs 0 immediately; state IDLE after release.
- Load hit: i_cpu_rd=1, i_hit=1, addr 0x100 -> o_stall=0, o_mem_req never set.
- Load miss, zero-wait: addr 0x0000_0124, ack every cycle, rdata 0xA0..0xA3 -> mem addrs 0x120,0x124,0x128,0x12C. fill_idx 0..3 carry data A0..A3; o_tag_we once with o_tag_addr=0x120; o_stall high exactly 5 cycles.
- Load miss with waits: ack delayed 3 cycles per word -> o_mem_addr stable during waits, one o_fill_we per ack, no early o_tag_we.
- Store: i_cpu_wr=1, addr 0x203, wdata 0xDEADBEEF, ack after 2 cycles -> o_mem_we=1, o_mem_addr=0x200, wdata held. o_wt_done one pulse on the ack cycle; stall drops in DONE.
- Reset after word 2 of a refill -> no o_tag_we. A following miss to the same line restarts at word 0 with the full 4-word sequence.
